// File: rtl/transpose_pkg.sv
// transpose_pkg: counter-width helper, element type and bank count shared by the transposer.
// Defining TRANSPOSE_PINGPONG_EN selects two banks; otherwise a single bank is built.
package transpose_pkg;
   localparam int N_BITS_DEFAULT = 32;
   typedef logic signed [N_BITS_DEFAULT-1:0] elem_t;
`ifdef TRANSPOSE_PINGPONG_EN
   localparam int NUM_BANKS = 2;
`else
   localparam int NUM_BANKS = 1;
`endif
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/transpose_bank.sv
// transpose_bank: one SIZE_A x SIZE_B element store with a clocked write port and a combinational read port.
module transpose_bank
   import transpose_pkg::*;
#(
   parameter int SIZE_A = 8,
   parameter int SIZE_B = 8,
   parameter int N_BITS = 32
) (
   input  logic                        clk,
   input  logic                        we,
   input  logic [cnt_w(SIZE_A)-1:0]    wr_row,
   input  logic [cnt_w(SIZE_B)-1:0]    wr_col,
   input  logic signed [N_BITS-1:0]    wr_data,
   input  logic [cnt_w(SIZE_A)-1:0]    rd_row,
   input  logic [cnt_w(SIZE_B)-1:0]    rd_col,
   output logic signed [N_BITS-1:0]    rd_data
);
   logic signed [N_BITS-1:0] mem [SIZE_A][SIZE_B];

   always_ff @(posedge clk)
      if (we) mem[wr_row][wr_col] <= wr_data;

   assign rd_data = mem[rd_row][rd_col];
endmodule

// File: rtl/transpose_stream.sv
// transpose_stream: element-serial SIZE_A x SIZE_B matrix transposer over valid/ready streams.
// Define TRANSPOSE_PINGPONG_EN for two banks so one matrix loads while the previous one drains.
module transpose_stream
   import transpose_pkg::*;
#(
   parameter int SIZE_A = 8,
   parameter int SIZE_B = 8,
   parameter int N_BITS = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [N_BITS-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic signed [N_BITS-1:0] out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last,
   output logic                     mat_done
);
   localparam int RW = cnt_w(SIZE_A);
   localparam int CW = cnt_w(SIZE_B);
   localparam logic [RW-1:0] R_MAX = RW'(SIZE_A - 1);
   localparam logic [CW-1:0] C_MAX = CW'(SIZE_B - 1);

   logic [RW-1:0]            wr_r, rd_j;
   logic [CW-1:0]            wr_c, rd_i;
   logic [NUM_BANKS-1:0]     full;
   logic                     wr_bank, rd_bank;
   logic                     wr_acc, wr_last, rd_acc, rd_last;
   logic signed [N_BITS-1:0] rd_data [NUM_BANKS];

   assign in_ready  = !full[wr_bank];
   assign wr_acc    = in_valid && in_ready;
   assign wr_last   = wr_acc && wr_r == R_MAX && wr_c == C_MAX;
   assign out_valid = full[rd_bank];
   assign out_last  = out_valid && rd_i == C_MAX && rd_j == R_MAX;
   assign rd_acc    = out_valid && out_ready;
   assign rd_last   = rd_acc && out_last;
   assign out_data  = out_valid ? rd_data[rd_bank] : '0;

   // read walks the stored matrix column by column: rd_j (input row) is the fast index
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_r     <= '0;
         wr_c     <= '0;
         rd_i     <= '0;
         rd_j     <= '0;
         full     <= '0;
         mat_done <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_c <= (wr_c == C_MAX) ? '0 : wr_c + 1'b1;
            if (wr_c == C_MAX) wr_r <= (wr_r == R_MAX) ? '0 : wr_r + 1'b1;
         end
         if (rd_acc) begin
            rd_j <= (rd_j == R_MAX) ? '0 : rd_j + 1'b1;
            if (rd_j == R_MAX) rd_i <= (rd_i == C_MAX) ? '0 : rd_i + 1'b1;
         end
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (wr_last && wr_bank == 1'(b)) full[b] <= 1'b1;
            if (rd_last && rd_bank == 1'(b)) full[b] <= 1'b0;
         end
         mat_done <= rd_last;
      end

`ifdef TRANSPOSE_PINGPONG_EN
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
      end else begin
         if (wr_last) wr_bank <= ~wr_bank;
         if (rd_last) rd_bank <= ~rd_bank;
      end
`else
   assign wr_bank = 1'b0;
   assign rd_bank = 1'b0;
`endif

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      transpose_bank #(.SIZE_A(SIZE_A), .SIZE_B(SIZE_B), .N_BITS(N_BITS)) u_bank (
         .clk     (clk),
         .we      (wr_acc && wr_bank == 1'(g)),
         .wr_row  (wr_r),
         .wr_col  (wr_c),
         .wr_data (in_data),
         .rd_row  (rd_j),
         .rd_col  (rd_i),
         .rd_data (rd_data[g])
      );
   end
endmodule
